serial_add_controller: RTL and testbench

- Bit-serial adder controller: sequences one shared single-bit full-adder cell over WIDTH cycles to add two WIDTH-bit operands.
- The carry is held in a register between bit positions.
- Used wherever area matters more than latency; the cell computes sum = a^b^c and carry = majority(a,b,c).
- Simple start/busy/done handshake toward the requesting logic.

---
 rtl/serial_add_controller.sv | 104 ++++++++++
 tb/tb_serial_add_controller.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_controller.sv
// Bit-serial adder: one full-adder cell stepped LSB-first over WIDTH cycles with a start/busy/done handshake.
// Optional subtract mode enabled by defining SERIAL_ADD_SUB_EN.
module serial_add_controller #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;

  logic             sum_bit_c;
  logic             carry_c;
  logic [WIDTH-1:0] b_load_c;
  logic             carry_load_c;

  // The single shared full-adder cell
  assign sum_bit_c = a_q[0] ^ b_q[0] ^ carry_q;
  assign carry_c   = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

  // Operand B and carry seed as loaded on an accepted start
`ifdef SERIAL_ADD_SUB_EN
  assign b_load_c     = sub ? ~b : b;
  assign carry_load_c = sub ? 1'b1 : cin;
`else
  assign b_load_c     = b;
  assign carry_load_c = cin;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b_load_c;
            carry_q <= carry_load_c;
            cnt_q   <= '0;
            sum     <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          sum     <= {sum_bit_c, sum[WIDTH-1:1]};
          carry_q <= carry_c;
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            cout  <= carry_c;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_controller.sv
// Directed self-checking bench for serial_add_controller (WIDTH=8); covers subtract when SERIAL_ADD_SUB_EN is defined.
module tb_serial_add_controller;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  serial_add_controller #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Tick until done is seen, at most limit edges; ok=0 on timeout
  task automatic wait_done(input int limit, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // One full operation with busy/done timing checks
  task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic cv, input logic [7:0] es, input logic ec);
    a = av; b = bv; cin = cv; start = 1'b1;
    tick();
    start = 1'b0;
    a = 8'hA5; b = 8'h5A; cin = ~cv;
    for (int i = 0; i < 8; i++) begin
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_nodone"}, 32'(done), 32'd0);
      tick();
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy_off"}, 32'(busy), 32'd0);
    chk({tag, "_sum"}, 32'(sum), 32'(es));
    chk({tag, "_cout"}, 32'(cout), 32'(ec));
    tick();
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_sum_hold"}, 32'(sum), 32'(es));
  endtask

  initial begin
    logic ok;
    int   dcount;
    int   t_prev;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b0;
`endif
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    rst = 1'b0;
    tick();

    run_op("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_op("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

    // Start pulsed on the 3rd busy cycle must be dropped
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    a = 8'h70; b = 8'h70; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(20, ok);
    chk("busy_start_done_seen", 32'(ok), 32'd1);
    chk("busy_start_sum", 32'(sum), 32'h02);
    chk("busy_start_cout", 32'(cout), 32'd0);
    dcount = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (done || busy) dcount++;
    end
    chk("busy_start_dropped", 32'(dcount), 32'd0);

    // Continuous start: one result every WIDTH+2 cycles
    a = 8'h11; b = 8'h22; cin = 1'b0; start = 1'b1;
    tick();
    t_prev = cyc;
    a = 8'hAA; b = 8'h55; cin = 1'b1;
    wait_done(20, ok);
    chk("cont1_done_seen", 32'(ok), 32'd1);
    chk("cont1_latency", 32'(cyc - t_prev), 32'd8);
    chk("cont1_sum", 32'(sum), 32'h33);
    chk("cont1_cout", 32'(cout), 32'd0);
    t_prev = cyc;
    a = 8'h80; b = 8'h80; cin = 1'b1;
    wait_done(20, ok);
    chk("cont2_done_seen", 32'(ok), 32'd1);
    chk("cont2_interval", 32'(cyc - t_prev), 32'd10);
    chk("cont2_sum", 32'(sum), 32'h01);
    chk("cont2_cout", 32'(cout), 32'd1);
    t_prev = cyc;
    a = 8'hC3; b = 8'h3C; cin = 1'b1;
    wait_done(20, ok);
    start = 1'b0;
    chk("cont3_done_seen", 32'(ok), 32'd1);
    chk("cont3_interval", 32'(cyc - t_prev), 32'd10);
    chk("cont3_sum", 32'(sum), 32'h00);
    chk("cont3_cout", 32'(cout), 32'd1);
    tick();
    tick();

    // Reset after 4 RUN edges abandons the operation
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("midrst_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_cout", 32'(cout), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done || busy) dcount++;
    end
    chk("midrst_no_done", 32'(dcount), 32'd0);
    run_op("after_rst", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);

    // Reset wins over start on the same edge
    a = 8'h01; b = 8'h02; rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    chk("rst_vs_start_busy", 32'(busy), 32'd0);
    tick();
    chk("rst_vs_start_idle", 32'(busy), 32'd0);

`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b1;
    run_op("sub_10_01", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b1);
    run_op("sub_01_02", 8'h01, 8'h02, 1'b0, 8'hFF, 1'b0);
    sub = 1'b0;
    run_op("nosub_10_01", 8'h10, 8'h01, 1'b0, 8'h11, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
